mips_regfile_sb: RTL and testbench

Parametrised architectural register file with an integrated scoreboard for the dynamic pipeline. It holds register data plus a per-register pending bit and producer tag. Issue marks a destination pending; tagged writeback retires it; flush clears all pending state. It sits between the issue stage, which reads operands and tags and reserves destinations, and the common writeback bus.

---
 rtl/mips_regfile_sb_pkg.sv | 34 +++
 rtl/mips_regfile_sb_if.sv | 35 +++
 rtl/mips_regfile_sb_read_port.sv | 67 ++++++
 rtl/mips_regfile_sb.sv | 128 ++++++++++++
 tb/tb_mips_regfile_sb.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_regfile_sb_pkg.sv
// Shared types and helpers for the MIPS register file with scoreboard.
// Optional build macro: MIPS_RF_BYPASS_EN (same-cycle writeback forwarding on read ports).
package mips_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_TAG_W  = 4;
    // Tags are zero-extended to this width before classification.
    localparam int MAX_TAG_W  = 16;

    typedef enum logic [1:0] {
        WB_WRITE  = 2'd0,
        WB_RETIRE = 2'd1,
        WB_STALE  = 2'd2
    } wb_cls_e;

    // A writeback to a busy register only counts if it comes from the newest producer.
    function automatic wb_cls_e wb_classify(
        input logic                 busy,
        input logic [MAX_TAG_W-1:0] tag,
        input logic [MAX_TAG_W-1:0] wb_tag
    );
        wb_cls_e cls;
        if (!busy) begin
            cls = WB_WRITE;
        end else if (tag == wb_tag) begin
            cls = WB_RETIRE;
        end else begin
            cls = WB_STALE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/mips_regfile_sb_if.sv
// Issue/read/writeback bundle between the issue stage, the writeback bus and the register file.
// Optional build macro: MIPS_RF_BYPASS_EN (affects read-port behaviour only).
interface mips_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int TAG_W  = 4
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NRD*TAG_W-1:0]  rd_tag;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_addr;
    logic [TAG_W-1:0]      iss_tag;
    logic                  wb_valid;
    logic [ADDR_W-1:0]     wb_addr;
    logic [TAG_W-1:0]      wb_tag;
    logic [DATA_W-1:0]     wb_data;
    logic                  flush;
    logic [ADDR_W:0]       busy_cnt;
    logic [DATA_W-1:0]     dbg_data;

    modport master (
        output rd_addr, iss_valid, iss_addr, iss_tag,
        output wb_valid, wb_addr, wb_tag, wb_data, flush,
        input  rd_data, rd_busy, rd_tag, busy_cnt, dbg_data
    );

    modport slave (
        input  rd_addr, iss_valid, iss_addr, iss_tag,
        input  wb_valid, wb_addr, wb_tag, wb_data, flush,
        output rd_data, rd_busy, rd_tag, busy_cnt, dbg_data
    );
endinterface

// File: rtl/mips_regfile_sb_read_port.sv
// One combinational read port: address mux, r0 forcing and optional writeback forwarding.
// Optional build macro: MIPS_RF_BYPASS_EN.
module mips_rf_read_port
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic [ADDR_W-1:0]                     addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]      data_arr,
    input  logic [2**ADDR_W-1:0]                  busy_arr,
    input  logic [2**ADDR_W-1:0][TAG_W-1:0]       tag_arr,
    input  logic                                  wb_write,
    input  logic                                  wb_retire,
    input  logic [ADDR_W-1:0]                     wb_addr,
    input  logic [DATA_W-1:0]                     wb_data,
    output logic [DATA_W-1:0]                     data,
    output logic                                  busy,
    output logic [TAG_W-1:0]                      tag
);

    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    // Stored-state lookup with register 0 hard-wired to zero.
    always_comb begin
        data_s = {DATA_W{1'b0}};
        busy_s = 1'b0;
        tag    = {TAG_W{1'b0}};
        if (addr != {ADDR_W{1'b0}}) begin
            data_s = data_arr[addr];
            busy_s = busy_arr[addr];
            tag    = tag_arr[addr];
        end else begin
            data_s = {DATA_W{1'b0}};
            busy_s = 1'b0;
            tag    = {TAG_W{1'b0}};
        end
    end

`ifdef MIPS_RF_BYPASS_EN
    logic hit_s;

    // A qualifying writeback already implies a nonzero address, so r0 can never hit.
    always_comb begin
        hit_s = wb_write && (wb_addr == addr);
        if (hit_s) begin
            data = wb_data;
            busy = busy_s & ~wb_retire;
        end else begin
            data = data_s;
            busy = busy_s;
        end
    end
`else
    logic unused_s;

    // Without forwarding the port shows stored state only.
    always_comb begin
        data     = data_s;
        busy     = busy_s;
        unused_s = ^{wb_write, wb_retire, wb_addr, wb_data};
    end
`endif

endmodule

// File: rtl/mips_regfile_sb.sv
// Architectural register file with per-register pending bit and producer tag (scoreboard).
// Optional build macro: MIPS_RF_BYPASS_EN (same-cycle writeback forwarding on read ports).
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NRD     = 2,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DBG_IDX = 28
) (
    input  logic           clk,
    input  logic           reset,
    mips_regfile_sb_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] data_r;
    logic [DEPTH-1:0]             busy_r;
    logic [DEPTH-1:0][TAG_W-1:0]  tag_r;
    logic [ADDR_W:0]              cnt_r;

    wb_cls_e wb_cls_s;
    logic    wb_ok_s;
    logic    wb_write_s;
    logic    wb_retire_s;
    logic    iss_ok_s;
    logic    cnt_inc_s;
    logic    cnt_dec_s;

    logic [NRD*DATA_W-1:0] rd_data_s;
    logic [NRD-1:0]        rd_busy_s;
    logic [NRD*TAG_W-1:0]  rd_tag_s;

    // Classify the writeback against pre-edge state and qualify the issue.
    always_comb begin
        wb_ok_s     = bus.wb_valid && (bus.wb_addr != {ADDR_W{1'b0}});
        wb_cls_s    = wb_classify(busy_r[bus.wb_addr],
                                  MAX_TAG_W'(tag_r[bus.wb_addr]),
                                  MAX_TAG_W'(bus.wb_tag));
        wb_write_s  = 1'b0;
        wb_retire_s = 1'b0;
        case (wb_cls_s)
            WB_WRITE: begin
                wb_write_s  = wb_ok_s;
                wb_retire_s = 1'b0;
            end
            WB_RETIRE: begin
                wb_write_s  = wb_ok_s;
                wb_retire_s = wb_ok_s;
            end
            default: begin
                wb_write_s  = 1'b0;
                wb_retire_s = 1'b0;
            end
        endcase
        iss_ok_s  = bus.iss_valid && (bus.iss_addr != {ADDR_W{1'b0}}) && !bus.flush;
        cnt_inc_s = iss_ok_s && !busy_r[bus.iss_addr];
        // A retire that is re-reserved in the same cycle leaves the bit set.
        cnt_dec_s = wb_retire_s && !(iss_ok_s && (bus.iss_addr == bus.wb_addr));
    end

    // Register data: writes happen even during flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
        end else if (wb_write_s) begin
            data_r[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard: issue is applied after retire so it wins on a shared address.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= '0;
            tag_r  <= '0;
        end else if (bus.flush) begin
            busy_r <= '0;
        end else begin
            if (wb_retire_s) begin
                busy_r[bus.wb_addr] <= 1'b0;
            end
            if (iss_ok_s) begin
                busy_r[bus.iss_addr] <= 1'b1;
                tag_r[bus.iss_addr]  <= bus.iss_tag;
            end
        end
    end

    // Pending count tracked incrementally; cannot exceed DEPTH-1 since r0 never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (bus.flush) begin
            cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            cnt_r <= cnt_r + (ADDR_W+1)'(cnt_inc_s) - (ADDR_W+1)'(cnt_dec_s);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        mips_rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .TAG_W  (TAG_W)
        ) u_rp (
            .addr      (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .data_arr  (data_r),
            .busy_arr  (busy_r),
            .tag_arr   (tag_r),
            .wb_write  (wb_write_s),
            .wb_retire (wb_retire_s),
            .wb_addr   (bus.wb_addr),
            .wb_data   (bus.wb_data),
            .data      (rd_data_s[i*DATA_W +: DATA_W]),
            .busy      (rd_busy_s[i]),
            .tag       (rd_tag_s[i*TAG_W +: TAG_W])
        );
    end

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.rd_tag   = rd_tag_s;
    assign bus.busy_cnt = cnt_r;
    assign bus.dbg_data = data_r[DBG_IDX];

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed self-checking bench for mips_regfile_sb; expected values are hand-computed.
module tb_mips_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int TAG_W  = 4;

`ifdef MIPS_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    mips_regfile_sb_if #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NRD (NRD), .TAG_W (TAG_W)
    ) bus ();

    mips_regfile_sb #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NRD (NRD), .TAG_W (TAG_W), .DBG_IDX (28)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_iss(input logic [4:0] a, input logic [3:0] t);
        bus.iss_valid = 1'b1;
        bus.iss_addr  = a;
        bus.iss_tag   = t;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_tag   = t;
        bus.wb_data  = d;
    endtask

    task automatic set_port(input int p, input logic [4:0] a);
        bus.rd_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    // Reads register a on port p and checks data and busy.
    task automatic chk_reg(input string tag, input int p, input logic [4:0] a,
                           input logic [31:0] d, input logic b);
        set_port(p, a);
        #1;
        check_vec({tag, "_data"}, bus.rd_data[p*DATA_W +: DATA_W], d);
        check_vec({tag, "_busy"}, 32'(bus.rd_busy[p]), 32'(b));
    endtask

    task automatic chk_tag(input string tag, input int p, input logic [4:0] a, input logic [3:0] t);
        set_port(p, a);
        #1;
        check_vec({tag, "_tag"}, 32'(bus.rd_tag[p*TAG_W +: TAG_W]), 32'(t));
    endtask

    task automatic chk_cnt(input string tag, input logic [5:0] c);
        check_vec({tag, "_cnt"}, 32'(bus.busy_cnt), 32'(c));
    endtask

    initial begin
        bus.rd_addr = '0;
        bus.iss_addr = '0; bus.iss_tag = '0;
        bus.wb_addr = '0; bus.wb_tag = '0; bus.wb_data = '0;
        idle();
        step(); step();
        reset = 1'b0;
        chk_cnt("rst0", 6'd0);
        chk_reg("rst0_r5", 0, 5'd5, 32'h0, 1'b0);

        // Populate some state, including a pending register, then reset it away.
        do_wb(5'd5, 4'd0, 32'h1234); step(); idle();
        do_wb(5'd28, 4'd0, 32'h0DB9); do_iss(5'd10, 4'd1); step(); idle();
        chk_reg("pre_r5", 0, 5'd5, 32'h1234, 1'b0);
        check_vec("pre_dbg", bus.dbg_data, 32'h0DB9);
        chk_cnt("pre", 6'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk_reg("rst_r5", 0, 5'd5, 32'h0, 1'b0);
        chk_reg("rst_r10", 1, 5'd10, 32'h0, 1'b0);
        chk_tag("rst_r10", 1, 5'd10, 4'd0);
        chk_cnt("rst", 6'd0);
        check_vec("rst_dbg", bus.dbg_data, 32'h0);

        // Tag retire.
        do_iss(5'd3, 4'd2); step(); idle();
        chk_reg("ret_iss", 0, 5'd3, 32'h0, 1'b1);
        chk_tag("ret_iss", 0, 5'd3, 4'd2);
        chk_cnt("ret_iss", 6'd1);
        do_wb(5'd3, 4'd2, 32'hAAAA); step(); idle();
        chk_reg("ret_wb", 0, 5'd3, 32'hAAAA, 1'b0);
        chk_cnt("ret_wb", 6'd0);

        // Stale discard after rename.
        do_iss(5'd4, 4'd1); step();
        do_iss(5'd4, 4'd7); step(); idle();
        chk_cnt("stale_iss", 6'd1);
        do_wb(5'd4, 4'd1, 32'h11); step(); idle();
        chk_reg("stale_wb", 1, 5'd4, 32'h0, 1'b1);
        chk_tag("stale_wb", 1, 5'd4, 4'd7);
        do_wb(5'd4, 4'd7, 32'h77); step(); idle();
        chk_reg("stale_ret", 1, 5'd4, 32'h77, 1'b0);
        chk_cnt("stale_ret", 6'd0);

        // Same-address collision of retire and issue.
        do_iss(5'd6, 4'd3); step(); idle();
        do_wb(5'd6, 4'd3, 32'h66); do_iss(5'd6, 4'd5); step(); idle();
        chk_reg("coll", 1, 5'd6, 32'h66, 1'b1);
        chk_tag("coll", 1, 5'd6, 4'd5);
        chk_reg("coll_p0", 0, 5'd6, 32'h66, 1'b1);
        chk_cnt("coll", 6'd1);
        do_wb(5'd6, 4'd5, 32'h60); step(); idle();
        chk_cnt("coll_ret", 6'd0);

        // Issue and retire on different addresses net to zero.
        do_iss(5'd8, 4'd1); step(); idle();
        do_iss(5'd11, 4'd2); do_wb(5'd8, 4'd1, 32'h88); step(); idle();
        chk_reg("cross_r8", 0, 5'd8, 32'h88, 1'b0);
        chk_reg("cross_r11", 1, 5'd11, 32'h0, 1'b1);
        chk_cnt("cross", 6'd1);
        do_wb(5'd11, 4'd2, 32'hBB); step(); idle();
        chk_cnt("cross_ret", 6'd0);

        // Flush with a concurrent matching writeback and an ignored issue.
        do_iss(5'd1, 4'd1); step();
        do_iss(5'd2, 4'd2); step();
        do_iss(5'd9, 4'd9); step(); idle();
        chk_cnt("fl_pre", 6'd3);
        bus.flush = 1'b1; do_wb(5'd2, 4'd2, 32'h22); do_iss(5'd31, 4'd4); step(); idle();
        chk_cnt("fl", 6'd0);
        chk_reg("fl_r2", 0, 5'd2, 32'h22, 1'b0);
        chk_reg("fl_r1", 1, 5'd1, 32'h0, 1'b0);
        chk_reg("fl_r9", 0, 5'd9, 32'h0, 1'b0);
        chk_reg("fl_r31", 1, 5'd31, 32'h0, 1'b0);

        // Register 0 ignores issue and writeback.
        do_iss(5'd0, 4'd5); do_wb(5'd0, 4'd0, 32'hFFFF); step(); idle();
        chk_reg("r0", 0, 5'd0, 32'h0, 1'b0);
        chk_tag("r0", 0, 5'd0, 4'd0);
        chk_cnt("r0", 6'd0);

        // Forwarding of a plain write.
        set_port(0, 5'd7);
        do_wb(5'd7, 4'd0, 32'hBEEF);
        #1;
        check_vec("byp_w", bus.rd_data[31:0], BYP ? 32'hBEEF : 32'h0);
        step(); idle();
        chk_reg("byp_w_next", 0, 5'd7, 32'hBEEF, 1'b0);

        // Forwarding of a retiring write clears busy the same cycle.
        do_iss(5'd12, 4'd3); step(); idle();
        set_port(1, 5'd12);
        do_wb(5'd12, 4'd3, 32'h12);
        #1;
        check_vec("byp_r_data", bus.rd_data[63:32], BYP ? 32'h12 : 32'h0);
        check_vec("byp_r_busy", 32'(bus.rd_busy[1]), BYP ? 32'd0 : 32'd1);
        step(); idle();
        chk_reg("byp_r_next", 1, 5'd12, 32'h12, 1'b0);

        // A stale writeback is never forwarded.
        do_iss(5'd13, 4'd4); step(); idle();
        set_port(0, 5'd13);
        do_wb(5'd13, 4'd9, 32'h99);
        #1;
        check_vec("byp_s_data", bus.rd_data[31:0], 32'h0);
        check_vec("byp_s_busy", 32'(bus.rd_busy[0]), 32'd1);
        step(); idle();
        chk_reg("byp_s_next", 0, 5'd13, 32'h0, 1'b1);
        chk_cnt("end", 6'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
